regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised integer register file for the NPC core: NUM_READ combinational read ports, one execute write-back port with source select (ALU result or link address PC+4), and a separate load write-back channel with valid/ready handshake. A per-register busy scoreboard marks registers awaiting load data, so the decoder can stall on read-after-load hazards. The block sits between decode (reads), execute (write-back) and the LSU (load return), and replaces the single-write, unscored register file.

Parameters:
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 32, register width; also PC width
NUM_READ, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = index 0 hardwired to zero and never busy; 0 = index 0 is an ordinary register
CNT_WIDTH, ADDR_WIDTH+1, width of outstanding-load counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
raddr  in  NUM_READ*ADDR_WIDTH  read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  out  NUM_READ*DATA_WIDTH  read data, same packing as raddr
rbusy  out  NUM_READ  1 = read port i register awaits load data
wen  in  1  execute write enable
wsel  in  1  0 = write wdata, 1 = write pc+4 (jal/jalr link)
waddr  in  ADDR_WIDTH  execute write index
wdata  in  DATA_WIDTH  ALU result
pc  in  DATA_WIDTH  PC of writing instruction
ld_issue  in  1  load issued; marks ld_issue_addr busy
ld_issue_addr  in  ADDR_WIDTH  load destination
ld_issue_ready  out  1  1 = ld_issue_addr is not already busy
ld_wb_valid  in  1  load data returned
ld_wb_addr  in  ADDR_WIDTH  load destination
ld_wb_data  in  DATA_WIDTH  load data
ld_wb_ready  out  1  load write-back accepted this cycle
pending_cnt  out  CNT_WIDTH  number of busy registers
waw_err  out  1  sticky: execute write hit a busy register
a0  out  DATA_WIDTH  register 10 contents (difftest/ebreak)

Behaviour:
- Reset (rst_n low, async): all registers 0, busy all clear, pending_cnt 0, waw_err 0, ld_wb_ready 0, ld_issue_ready 0, rbusy 0. Outputs stay forced low while rst_n low; reset mid-load drops the load silently.
- Single physical write port. Execute write has priority. ld_wb_ready = rst_n & !(wen & waddr writable). Load fires when ld_wb_valid & ld_wb_ready; LSU holds valid/addr/data stable until fire.
- Writable: ZERO_REG=1 -> index 0 writes discarded, reads 0, never busy. Execute write data = wsel ? pc+4 (mod 2^DATA_WIDTH) : wdata.
- Reads combinational with write-through: if raddr matches the index being written this cycle (execute write or load fire), rdata = that write data; otherwise array value.
- Scoreboard, per register: set on ld_issue & ld_issue_ready (ignored for index 0 when ZERO_REG=1); cleared on load fire to that index. Issue and fire to same index in same cycle: clear wins only if busy was already set, otherwise set wins; net effect equals the old load completing and the new load pending. ld_issue_ready = rst_n & !busy[ld_issue_addr] (index 0 with ZERO_REG=1 always ready). Issue while not ready: no state change.
- rbusy[i] = busy[raddr_i] & !(load fire to raddr_i this cycle).
- pending_cnt = population count of busy, updated registered with busy; never exceeds 2^ADDR_WIDTH.
- Execute write to a busy register: write performed, busy unchanged, waw_err set and held until reset.
- Load fire to a non-busy register: data written, no counter change (no underflow).
- a0 = rf[10] after any write-through, same timing as array (registered value).

Test Plan:
- Reset then read all ports -> rdata 0, rbusy 0, pending_cnt 0; wen=1, waddr=0, wdata=0xDEADBEEF -> raddr0=0 still reads 0.
- wen=1, wsel=1, waddr=1, pc=0x80000000 -> next cycle x1 = 0x80000004; same-cycle read of x1 returns 0x80000004 via write-through.
- ld_issue to x5 -> rbusy on x5=1, pending_cnt=1, second issue to x5 -> ld_issue_ready=0, count stays 1; ld_wb x5=0x1234 fire -> x5=0x1234, rbusy 0 same cycle, count 0.
- ld_wb_valid and wen same cycle -> ld_wb_ready=0, execute write lands; load fires next cycle when wen drops.
- wen to busy x7 -> waw_err=1 and stays 1 after later traffic; clears only on rst_n low.
- Issue loads to x3,x4; assert rst_n low mid-wait -> all busy clear, pending_cnt 0, x3/x4 read 0 immediately (async).

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with one execute write-back port, a valid/ready
// load write-back channel sharing the single physical write port, and a
// per-register busy scoreboard for read-after-load hazard detection.
module regfile_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
  output logic [NUM_READ-1:0]            rbusy,
  input  logic                           wen,
  input  logic                           wsel,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH-1:0]          pc,
  input  logic                           ld_issue,
  input  logic [ADDR_WIDTH-1:0]          ld_issue_addr,
  output logic                           ld_issue_ready,
  input  logic                           ld_wb_valid,
  input  logic [ADDR_WIDTH-1:0]          ld_wb_addr,
  input  logic [DATA_WIDTH-1:0]          ld_wb_data,
  output logic                           ld_wb_ready,
  output logic [CNT_WIDTH-1:0]           pending_cnt,
  output logic                           waw_err,
  output logic [DATA_WIDTH-1:0]          a0
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  waw_q;

  // Index 0 is read-only zero when ZERO_REG is set.
  function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic                  ex_we;
  logic [DATA_WIDTH-1:0] ex_data;
  logic                  ld_fire;
  logic                  ld_we;
  logic                  issue_set;
  logic                  ld_clr;

  // Execute write owns the port; a load only fires when the port is free.
  assign ex_we          = wen & writable(waddr);
  assign ex_data        = wsel ? (pc + DATA_WIDTH'(4)) : wdata;
  assign ld_wb_ready    = rst_n & ~ex_we;
  assign ld_fire        = ld_wb_valid & ld_wb_ready;
  assign ld_we          = ld_fire & writable(ld_wb_addr);
  assign ld_issue_ready = rst_n & ~busy[ld_issue_addr];
  assign issue_set      = ld_issue & ld_issue_ready & writable(ld_issue_addr);
  assign ld_clr         = ld_we & busy[ld_wb_addr];

  // Register array: execute write first, otherwise the firing load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array itself is reset so every register reads zero after reset, not just the control state.
      for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
    end else if (ex_we) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      rf[waddr] <= ex_data;
    end else if (ld_we) begin
      rf[ld_wb_addr] <= ld_wb_data;
    end
  end

  // Scoreboard: clear on load fire, then set on accepted issue (set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (ld_we)     busy[ld_wb_addr]    <= 1'b0;
      if (issue_set) busy[ld_issue_addr] <= 1'b1;
    end
  end

  // Outstanding-load count tracks the population of busy incrementally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + CNT_WIDTH'(issue_set) - CNT_WIDTH'(ld_clr);
  end

  // Sticky flag for an execute write landing on a register awaiting a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    waw_q <= 1'b0;
    else if (ex_we && busy[waddr]) waw_q <= 1'b1;
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    // Read port with write-through of this cycle's write data.
    always_comb begin
      // NOTE: default first so every path assigns rd and no latch is inferred.
      rd = rf[ra];
      if (!rst_n || !writable(ra))        rd = '0;
      else if (ex_we && ra == waddr)      rd = ex_data;
      else if (ld_we && ra == ld_wb_addr) rd = ld_wb_data;
    end

    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[i] = rst_n & busy[ra] & ~(ld_fire && ld_wb_addr == ra);
  end

  assign pending_cnt = cnt;
  assign waw_err     = waw_q;

  if (NUM_REGS > 10) begin : g_a0
    assign a0 = rf[10];
  end else begin : g_no_a0
    assign a0 = '0;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed bench for regfile_scoreboard against a behavioural
// model of the architectural registers and the set of pending loads.
module tb_regfile_scoreboard;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int CW = AW + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]  rbusy;
  logic           wen, wsel;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata, pc;
  logic           ld_issue;
  logic [AW-1:0]  ld_issue_addr;
  logic           ld_issue_ready;
  logic           ld_wb_valid;
  logic [AW-1:0]  ld_wb_addr;
  logic [DW-1:0]  ld_wb_data;
  logic           ld_wb_ready;
  logic [CW-1:0]  pending_cnt;
  logic           waw_err;
  logic [DW-1:0]  a0;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR),
                       .ZERO_REG(1), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .wsel(wsel), .waddr(waddr), .wdata(wdata), .pc(pc),
    .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
    .ld_issue_ready(ld_issue_ready), .ld_wb_valid(ld_wb_valid),
    .ld_wb_addr(ld_wb_addr), .ld_wb_data(ld_wb_data),
    .ld_wb_ready(ld_wb_ready), .pending_cnt(pending_cnt),
    .waw_err(waw_err), .a0(a0));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_rf [32];
  bit            m_pend [32];   // register awaits load data
  bit            m_waw;

  task automatic m_reset();
    for (int r = 0; r < 32; r++) begin m_rf[r] = '0; m_pend[r] = 0; end
    m_waw = 0;
  endtask

  function automatic bit m_exec();
    return rst_n && wen && waddr != 0;
  endfunction
  function automatic bit m_wb_ready();
    return rst_n && !m_exec();
  endfunction
  function automatic bit m_fire();
    return ld_wb_valid && m_wb_ready();
  endfunction
  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (!rst_n || a == 0) return '0;
    if (m_exec() && a == waddr) return wsel ? pc + 32'd4 : wdata;
    if (m_fire() && a == ld_wb_addr) return ld_wb_data;
    return m_rf[a];
  endfunction
  function automatic bit m_rbusy(input logic [AW-1:0] a);
    return rst_n && m_pend[a] && !(m_fire() && ld_wb_addr == a);
  endfunction
  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  // Apply one rising edge to the model, then advance the DUT past it.
  task automatic tick();
    if (!rst_n) m_reset();
    else begin
      bit fire, iss;
      fire = m_fire();
      iss  = ld_issue && ld_issue_addr != 0 && !m_pend[ld_issue_addr];
      if (m_exec() && m_pend[waddr]) m_waw = 1;
      if (m_exec()) m_rf[waddr] = wsel ? pc + 32'd4 : wdata;
      else if (fire && ld_wb_addr != 0) m_rf[ld_wb_addr] = ld_wb_data;
      if (fire) m_pend[ld_wb_addr] = 0;
      if (iss)  m_pend[ld_issue_addr] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return rdata[p*DW +: DW];
  endfunction
  task automatic set_ra(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask
  task automatic idle();
    wen = 0; wsel = 0; waddr = '0; wdata = '0; pc = '0;
    ld_issue = 0; ld_issue_addr = '0;
    ld_wb_valid = 0; ld_wb_addr = '0; ld_wb_data = '0;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    rst_n = 0; idle(); raddr = '0;
    #2;
    for (int p = 0; p < NR; p++) begin
      set_ra(p, AW'(p + 3)); #1;
      checks++; if (rd(p) !== '0) begin errors++; $display("FAIL reset_rdata%0d: got %h want 0", p, rd(p)); end
      checks++; if (rbusy[p] !== 1'b0) begin errors++; $display("FAIL reset_rbusy%0d: got %b want 0", p, rbusy[p]); end
    end
    checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", pending_cnt); end
    checks++; if (ld_wb_ready !== 1'b0 || ld_issue_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got wb=%b iss=%b want 0 0", ld_wb_ready, ld_issue_ready); end
    checks++; if (waw_err !== 1'b0 || a0 !== '0) begin errors++; $display("FAIL reset_waw_a0: got %b %h want 0 0", waw_err, a0); end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_zero_reg();
    wen = 1; waddr = 0; wdata = 32'hDEADBEEF; set_ra(0, 0);
    #2;
    checks++; if (rd(0) !== '0) begin errors++; $display("FAIL zero_wt: got %h want 0", rd(0)); end
    checks++; if (ld_wb_ready !== 1'b1) begin errors++; $display("FAIL zero_wb_ready: got %b want 1", ld_wb_ready); end
    tick(); idle(); #2;
    checks++; if (rd(0) !== '0) begin errors++; $display("FAIL zero_after: got %h want 0", rd(0)); end
  endtask

  task automatic test_link();
    wen = 1; wsel = 1; waddr = 1; pc = 32'h8000_0000; set_ra(0, 1);
    #2;
    checks++; if (rd(0) !== 32'h8000_0004) begin errors++; $display("FAIL link_wt: got %h want 80000004", rd(0)); end
    tick(); idle(); #2;
    checks++; if (rd(0) !== 32'h8000_0004) begin errors++; $display("FAIL link_reg: got %h want 80000004", rd(0)); end
    wen = 1; wsel = 1; waddr = 2; pc = 32'hFFFF_FFFE; set_ra(1, 2);
    #2;
    checks++; if (rd(1) !== 32'h0000_0002) begin errors++; $display("FAIL link_wrap: got %h want 00000002", rd(1)); end
    tick(); idle();
  endtask

  task automatic test_load_basic();
    ld_issue = 1; ld_issue_addr = 5; set_ra(1, 5);
    #2;
    checks++; if (ld_issue_ready !== 1'b1) begin errors++; $display("FAIL ld_first_ready: got %b want 1", ld_issue_ready); end
    tick(); #2;
    checks++; if (rbusy[1] !== 1'b1) begin errors++; $display("FAIL ld_rbusy: got %b want 1", rbusy[1]); end
    checks++; if (pending_cnt !== CW'(1)) begin errors++; $display("FAIL ld_cnt1: got %0d want 1", pending_cnt); end
    checks++; if (ld_issue_ready !== 1'b0) begin errors++; $display("FAIL ld_second_ready: got %b want 0", ld_issue_ready); end
    tick(); ld_issue = 0; #2;
    checks++; if (pending_cnt !== CW'(1)) begin errors++; $display("FAIL ld_cnt_hold: got %0d want 1", pending_cnt); end
    ld_wb_valid = 1; ld_wb_addr = 5; ld_wb_data = 32'h1234; #1;
    checks++; if (ld_wb_ready !== 1'b1 || rd(1) !== 32'h1234 || rbusy[1] !== 1'b0) begin errors++; $display("FAIL ld_fire: got ready=%b rd=%h busy=%b want 1 1234 0", ld_wb_ready, rd(1), rbusy[1]); end
    tick(); idle(); #2;
    checks++; if (rd(1) !== 32'h1234 || pending_cnt !== '0) begin errors++; $display("FAIL ld_done: got rd=%h cnt=%0d want 1234 0", rd(1), pending_cnt); end
  endtask

  task automatic test_wb_conflict();
    ld_issue = 1; ld_issue_addr = 6; tick(); idle();
    wen = 1; waddr = 8; wdata = 32'hAAAA; set_ra(0, 8); set_ra(1, 6);
    ld_wb_valid = 1; ld_wb_addr = 6; ld_wb_data = 32'h6666;
    #2;
    checks++; if (ld_wb_ready !== 1'b0 || rd(0) !== 32'hAAAA || rbusy[1] !== 1'b1) begin errors++; $display("FAIL conflict_block: got ready=%b rd0=%h busy=%b want 0 aaaa 1", ld_wb_ready, rd(0), rbusy[1]); end
    tick(); wen = 0; #2;
    checks++; if (ld_wb_ready !== 1'b1 || rd(1) !== 32'h6666 || rbusy[1] !== 1'b0) begin errors++; $display("FAIL conflict_fire: got ready=%b rd1=%h busy=%b want 1 6666 0", ld_wb_ready, rd(1), rbusy[1]); end
    tick(); idle(); #2;
    checks++; if (rd(0) !== 32'hAAAA || rd(1) !== 32'h6666 || pending_cnt !== '0) begin errors++; $display("FAIL conflict_after: got %h %h cnt=%0d want aaaa 6666 0", rd(0), rd(1), pending_cnt); end
  endtask

  task automatic test_waw();
    ld_issue = 1; ld_issue_addr = 7; tick(); idle();
    checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL waw_pre: got %b want 0", waw_err); end
    wen = 1; waddr = 7; wdata = 32'h77; tick(); idle();
    set_ra(0, 7); #2;
    checks++; if (waw_err !== 1'b1 || rbusy[0] !== 1'b1 || rd(0) !== 32'h77 || pending_cnt !== CW'(1)) begin errors++; $display("FAIL waw_set: got waw=%b busy=%b rd=%h cnt=%0d want 1 1 77 1", waw_err, rbusy[0], rd(0), pending_cnt); end
    ld_wb_valid = 1; ld_wb_addr = 7; ld_wb_data = 32'h700; tick(); idle();
    wen = 1; waddr = 9; wdata = 32'h99; tick(); idle(); #2;
    checks++; if (waw_err !== 1'b1 || pending_cnt !== '0 || rd(0) !== 32'h700) begin errors++; $display("FAIL waw_sticky: got waw=%b cnt=%0d rd=%h want 1 0 700", waw_err, pending_cnt, rd(0)); end
  endtask

  // ---------------- randomised test ----------------
  task automatic test_random();
    bit lsu_v = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit fire;
      wen   = ($urandom_range(0, 2) == 0);
      wsel  = $urandom_range(0, 1);
      waddr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 11));
      wdata = $urandom;
      pc    = $urandom;
      ld_issue      = $urandom_range(0, 1);
      ld_issue_addr = AW'($urandom_range(0, 11));
      if (!lsu_v && $urandom_range(0, 1) == 1) begin
        lsu_v = 1;
        ld_wb_addr = AW'($urandom_range(0, 11));
        ld_wb_data = $urandom;
      end
      ld_wb_valid = lsu_v;
      set_ra(0, AW'($urandom_range(0, 11)));
      set_ra(1, ($urandom_range(0, 1) == 1) ? ld_wb_addr : waddr);
      #2;
      for (int p = 0; p < NR; p++) begin
        logic [AW-1:0] a;
        a = raddr[p*AW +: AW];
        checks++; if (rd(p) !== m_read(a)) begin errors++; $display("FAIL rnd_rdata%0d cyc %0d x%0d: got %h want %h", p, cyc, a, rd(p), m_read(a)); end
        checks++; if (rbusy[p] !== m_rbusy(a)) begin errors++; $display("FAIL rnd_rbusy%0d cyc %0d x%0d: got %b want %b", p, cyc, a, rbusy[p], m_rbusy(a)); end
      end
      checks++; if (ld_wb_ready !== m_wb_ready()) begin errors++; $display("FAIL rnd_wb_ready cyc %0d: got %b want %b", cyc, ld_wb_ready, m_wb_ready()); end
      checks++; if (ld_issue_ready !== (ld_issue_addr == 0 || !m_pend[ld_issue_addr])) begin errors++; $display("FAIL rnd_iss_ready cyc %0d: got %b", cyc, ld_issue_ready); end
      checks++; if (int'(pending_cnt) != m_count()) begin errors++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", cyc, pending_cnt, m_count()); end
      checks++; if (waw_err !== m_waw || a0 !== m_rf[10]) begin errors++; $display("FAIL rnd_waw_a0 cyc %0d: got %b %h want %b %h", cyc, waw_err, a0, m_waw, m_rf[10]); end
      fire = m_fire();
      tick();
      if (fire) lsu_v = 0;
    end
    idle();
  endtask

  task automatic test_reset_mid_load();
    rst_n = 0; tick(); rst_n = 1; idle(); tick();
    wen = 1; waddr = 3; wdata = 32'h33; tick();
    waddr = 4; wdata = 32'h44; tick(); idle();
    ld_issue = 1; ld_issue_addr = 3; tick();
    ld_issue_addr = 4; tick(); idle();
    tick();
    set_ra(0, 3); set_ra(1, 4); #2;
    checks++; if (pending_cnt !== CW'(2) || rbusy !== 2'b11 || rd(0) !== 32'h33) begin errors++; $display("FAIL mid_pre: got cnt=%0d busy=%b rd0=%h want 2 11 33", pending_cnt, rbusy, rd(0)); end
    rst_n = 0; #1;
    checks++; if (rd(0) !== '0 || rd(1) !== '0) begin errors++; $display("FAIL mid_rdata: got %h %h want 0 0", rd(0), rd(1)); end
    checks++; if (pending_cnt !== '0 || rbusy !== 2'b00 || waw_err !== 1'b0) begin errors++; $display("FAIL mid_state: got cnt=%0d busy=%b waw=%b want 0 00 0", pending_cnt, rbusy, waw_err); end
    tick(); rst_n = 1; #2;
    checks++; if (rd(0) !== '0 || ld_issue_ready !== 1'b1 || pending_cnt !== '0) begin errors++; $display("FAIL mid_release: got rd=%h iss=%b cnt=%0d want 0 1 0", rd(0), ld_issue_ready, pending_cnt); end
    tick();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_zero_reg();
    test_link();
    test_load_basic();
    test_wb_conflict();
    test_waw();
    test_random();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
